// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: operation encodings and small helpers shared by the
// multi-input logic unit and its reduction datapath.
package logic_unit_pkg;

  localparam int MODE_W    = 3;
  localparam int N_IN_MIN  = 2;
  localparam int N_IN_MAX  = 16;

  typedef enum logic [MODE_W-1:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_NAND = 3'd2,
    MODE_NOR  = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_PASS = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  function automatic logic isReserved(input logic [MODE_W-1:0] mode);
    return (mode == MODE_RSVD);
  endfunction

endpackage

// File: rtl/logic_reduce.sv
// logic_reduce: purely combinational per-lane reduction of N_IN operands.
// Each bit lane is reduced independently across all inputs.
module logic_reduce
  import logic_unit_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int WIDTH = 1
) (
  input  logic [N_IN*WIDTH-1:0] data,
  input  logic [MODE_W-1:0]     mode,
  output logic [WIDTH-1:0]      result,
  output logic                  err
);

  logic [WIDTH-1:0] andAll;
  logic [WIDTH-1:0] orAll;
  logic [WIDTH-1:0] xorAll;

  // Fold every input into lane-wise AND, OR and XOR accumulators.
  always_comb begin
    andAll = '1;
    orAll  = '0;
    xorAll = '0;
    for (int k = 0; k < N_IN; k++) begin
      andAll = andAll & data[k*WIDTH +: WIDTH];
      orAll  = orAll  | data[k*WIDTH +: WIDTH];
      xorAll = xorAll ^ data[k*WIDTH +: WIDTH];
    end
  end

  // Pick the requested operation; the reserved code yields zero and flags err.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (mode)
      MODE_AND:  result = andAll;
      MODE_OR:   result = orAll;
      MODE_NAND: result = ~andAll;
      MODE_NOR:  result = ~orAll;
      MODE_XOR:  result = xorAll;
      MODE_XNOR: result = ~xorAll;
      MODE_PASS: result = data[WIDTH-1:0];
      MODE_RSVD: begin
        result = '0;
        err    = isReserved(mode);
      end
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multi_input_logic_unit.sv
// multi_input_logic_unit: registered N-input logic reduction with a
// valid/ready handshake, a one-entry skid buffer behind the output register,
// and a saturating counter of delivered results that changed value.
module multi_input_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*WIDTH-1:0]  in_data,
  input  logic [MODE_W-1:0]      in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_err,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       change_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] newData;
  logic             newErr;
  logic             transfer;
  logic             deliver;

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q,  outData_d;
  logic             outErr_q,   outErr_d;
  logic             skidValid_q, skidValid_d;
  logic [WIDTH-1:0] skidData_q,  skidData_d;
  logic             skidErr_q,   skidErr_d;
  logic             inReady_q,   inReady_d;
  logic [WIDTH:0]   lastVal_q,   lastVal_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH:0]   deliveredVal;

  logic_reduce #(
    .N_IN  (N_IN),
    .WIDTH (WIDTH)
  ) u_reduce (
    .data   (in_data),
    .mode   (in_mode),
    .result (newData),
    .err    (newErr)
  );

  assign transfer     = in_valid & inReady_q;
  assign deliver      = outValid_q & out_ready;
  assign deliveredVal = {outErr_q, outData_q};

  // Move results between input, skid entry and output register; the skid
  // entry always drains into the output register before new data does.
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outErr_d    = outErr_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    skidErr_d   = skidErr_q;
    if (deliver) begin
      if (skidValid_q) begin
        outValid_d = 1'b1;
        outData_d  = skidData_q;
        outErr_d   = skidErr_q;
        if (transfer) begin
          skidValid_d = 1'b1;
          skidData_d  = newData;
          skidErr_d   = newErr;
        end else begin
          skidValid_d = 1'b0;
        end
      end else if (transfer) begin
        outValid_d = 1'b1;
        outData_d  = newData;
        outErr_d   = newErr;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (transfer) begin
      if (!outValid_q) begin
        outValid_d = 1'b1;
        outData_d  = newData;
        outErr_d   = newErr;
      end else begin
        skidValid_d = 1'b1;
        skidData_d  = newData;
        skidErr_d   = newErr;
      end
    end
    inReady_d = ~skidValid_d;
  end

  // Track the last delivered value and count deliveries that changed it.
  always_comb begin
    lastVal_d = lastVal_q;
    cnt_d     = cnt_q;
    if (deliver) begin
      lastVal_d = deliveredVal;
      if ((deliveredVal != lastVal_q) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  // Register all state; reset empties both entries and holds off new input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outErr_q    <= 1'b0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      skidErr_q   <= 1'b0;
      inReady_q   <= 1'b0;
      lastVal_q   <= '0;
      cnt_q       <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outErr_q    <= outErr_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      skidErr_q   <= skidErr_d;
      inReady_q   <= inReady_d;
      lastVal_q   <= lastVal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = inReady_q;
  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign out_err    = outErr_q;
  assign change_cnt = cnt_q;

endmodule

// File: tb/tb_multi_input_logic_unit.sv
// tb_multi_input_logic_unit: two instances (3x1-bit with 16-bit counter,
// 4x8-bit with 2-bit counter) checked every cycle against a FIFO-level model.
module tb_multi_input_logic_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv0, ir0, ov0, or0, oe0, clr0;
  logic [2:0] id0, im0;
  logic [0:0] od0;
  logic [15:0] cc0;

  logic        iv1, ir1, ov1, or1, oe1, clr1;
  logic [31:0] id1;
  logic [2:0]  im1;
  logic [7:0]  od1;
  logic [1:0]  cc1;

  int nCheck = 0;
  int nPass  = 0;

  multi_input_logic_unit #(.N_IN(3), .WIDTH(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .in_mode(im0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .out_err(oe0), .cnt_clr(clr0), .change_cnt(cc0)
  );

  multi_input_logic_unit #(.N_IN(4), .WIDTH(8), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .in_mode(im1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_err(oe1), .cnt_clr(clr1), .change_cnt(cc1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCheck++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected result {err, lanes} computed by counting ones per lane.
  function automatic logic [8:0] refResult(input logic [31:0] data, input int nIn,
                                           input int w, input logic [2:0] mode);
    logic [7:0] r;
    int ones;
    logic b;
    r = 8'h00;
    if (mode == 3'd7) return 9'h100;
    for (int l = 0; l < w; l++) begin
      ones = 0;
      for (int k = 0; k < nIn; k++) ones += int'(data[k*w + l]);
      case (mode)
        3'd0: b = (ones == nIn);
        3'd1: b = (ones > 0);
        3'd2: b = (ones != nIn);
        3'd3: b = (ones == 0);
        3'd4: b = (ones % 2) == 1;
        3'd5: b = (ones % 2) == 0;
        default: b = data[l];
      endcase
      r[l] = b;
    end
    return {1'b0, r};
  endfunction

  // Model state: a 2-deep result FIFO per instance plus counter bookkeeping.
  logic [8:0] fifo [2][2];
  int         fn [2];
  logic       rdyExp [2];
  logic [8:0] lastExp [2];
  int         cntExp [2];
  int         cntMax [2];
  bit         prevStall [2];
  logic [8:0] prevOut [2];
  bit         modelInit = 1'b0;

  always @(negedge clk) begin
    logic [8:0]  act [2];
    logic        ovA [2], irA [2], ivA [2], ordyA [2], clrA [2];
    logic [31:0] ccA [2], dataA [2];
    logic [2:0]  modeA [2];
    int          nInA [2], wA [2];
    logic [8:0]  v;
    bit          dlv, xfr;

    act[0] = {oe0, 7'd0, od0};  act[1] = {oe1, od1};
    ovA[0] = ov0;  ovA[1] = ov1;
    irA[0] = ir0;  irA[1] = ir1;
    ivA[0] = iv0;  ivA[1] = iv1;
    ordyA[0] = or0; ordyA[1] = or1;
    clrA[0] = clr0; clrA[1] = clr1;
    ccA[0] = 32'(cc0); ccA[1] = 32'(cc1);
    dataA[0] = 32'(id0); dataA[1] = id1;
    modeA[0] = im0; modeA[1] = im1;
    nInA[0] = 3; nInA[1] = 4;
    wA[0] = 1;   wA[1] = 8;

    for (int d = 0; d < 2; d++) begin
      if (modelInit) begin
        checkOutput($sformatf("dut%0d.out_valid", d), 32'(ovA[d]), 32'(fn[d] > 0));
        if (fn[d] > 0)
          checkOutput($sformatf("dut%0d.result", d), 32'(act[d]), 32'(fifo[d][0]));
        checkOutput($sformatf("dut%0d.in_ready", d), 32'(irA[d]), 32'(rdyExp[d]));
        checkOutput($sformatf("dut%0d.change_cnt", d), ccA[d], 32'(cntExp[d]));
        if (prevStall[d]) begin
          checkOutput($sformatf("dut%0d.stall_valid", d), 32'(ovA[d]), 32'd1);
          checkOutput($sformatf("dut%0d.stall_hold", d), 32'(act[d]), 32'(prevOut[d]));
        end
      end
      if (!rst_n) begin
        fn[d] = 0; rdyExp[d] = 1'b0; lastExp[d] = '0; cntExp[d] = 0;
        prevStall[d] = 1'b0;
        modelInit = 1'b1;
      end else if (modelInit) begin
        dlv = (fn[d] > 0) && ordyA[d];
        xfr = ivA[d] && rdyExp[d];
        prevStall[d] = (fn[d] > 0) && !ordyA[d];
        prevOut[d] = fifo[d][0];
        if (dlv) begin
          v = fifo[d][0];
          if (v != lastExp[d] && cntExp[d] < cntMax[d]) cntExp[d]++;
          lastExp[d] = v;
          fifo[d][0] = fifo[d][1];
          fn[d]--;
        end
        if (clrA[d]) cntExp[d] = 0;
        if (xfr && fn[d] < 2) begin
          fifo[d][fn[d]] = refResult(dataA[d], nInA[d], wA[d], modeA[d]);
          fn[d]++;
        end
        rdyExp[d] = (fn[d] < 2);
      end
    end
  end

  task automatic applyStimulus();
    logic [7:0] tt [6];
    logic [2:0] ml [6];
    logic [7:0] alt [5];
    logic       seq4 [4];
    int xfers, cyc;

    tt[0] = 8'b0000_0001; ml[0] = 3'd3;
    tt[1] = 8'b1000_0000; ml[1] = 3'd0;
    tt[2] = 8'b1111_1110; ml[2] = 3'd1;
    tt[3] = 8'b0111_1111; ml[3] = 3'd2;
    tt[4] = 8'b1001_0110; ml[4] = 3'd4;
    tt[5] = 8'b0110_1001; ml[5] = 3'd5;

    // Reset
    tick(3);
    checkOutput("reset_out_valid", 32'(ov0), 32'd0);
    checkOutput("reset_out_data", 32'(od1), 32'd0);
    checkOutput("reset_in_ready", 32'(ir1), 32'd0);
    checkOutput("reset_cnt", 32'(cc0), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_reset", 32'(ir0), 32'd1);

    // Truth-table sweep, 3 inputs x 1 lane, full throughput
    or0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int v = 0; v < 8; v++) begin
        iv0 = 1'b1; id0 = 3'(v); im0 = ml[i];
        tick();
        checkOutput($sformatf("tt_mode%0d_in%0d", ml[i], v), {30'd0, ov0, od0}, {30'd0, 1'b1, tt[i][v]});
      end
    end
    iv0 = 1'b0;
    tick(2);

    // Counter: deliver 0, clear, then 0,1,1,0
    im0 = 3'd6; iv0 = 1'b1; id0 = 3'd0; tick();
    iv0 = 1'b0; tick(2);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    checkOutput("cnt_cleared", 32'(cc0), 32'd0);
    seq4[0] = 1'b0; seq4[1] = 1'b1; seq4[2] = 1'b1; seq4[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv0 = 1'b1; id0 = {2'b00, seq4[i]}; tick();
    end
    iv0 = 1'b0; tick(2);
    checkOutput("cnt_0110", 32'(cc0), 32'd2);
    iv0 = 1'b1; id0 = 3'd1; tick();
    iv0 = 1'b0; clr0 = 1'b1; tick(); clr0 = 1'b0;
    checkOutput("clr_beats_incr", 32'(cc0), 32'd0);
    iv0 = 1'b1; id0 = 3'd1; tick();
    iv0 = 1'b0; tick(2);
    checkOutput("clr_keeps_reference", 32'(cc0), 32'd0);

    // Wide XOR and reserved mode
    or1 = 1'b1; iv1 = 1'b1; id1 = 32'h01AA_CCF0; im1 = 3'd4; tick();
    checkOutput("xor4x8", {23'd0, oe1, od1}, 32'h097);
    im1 = 3'd7; tick();
    checkOutput("reserved", {23'd0, oe1, od1}, 32'h100);
    iv1 = 1'b0; tick(2);

    // Backpressure: A then B with out_ready low
    or1 = 1'b0; iv1 = 1'b1; im1 = 3'd6; id1 = 32'h11; tick();
    id1 = 32'h22; tick();
    checkOutput("ready_low_after_B", 32'(ir1), 32'd0);
    iv1 = 1'b0; tick();
    checkOutput("stalled_A", 32'(od1), 32'h11);
    or1 = 1'b1; tick();
    checkOutput("B_after_A", {30'd0, ov1, ir1}, 32'd3);
    checkOutput("B_data", 32'(od1), 32'h22);
    tick();
    checkOutput("drained", 32'(ov1), 32'd0);

    // 2-bit counter saturation
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    alt[0] = 8'hAA; alt[1] = 8'h55; alt[2] = 8'hAA; alt[3] = 8'h55; alt[4] = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      iv1 = 1'b1; id1 = {24'd0, alt[i]}; tick();
    end
    iv1 = 1'b0; tick(2);
    checkOutput("cnt_saturate", 32'(cc1), 32'd3);

    // Reset with the skid entry full
    or1 = 1'b0; iv1 = 1'b1; id1 = 32'h33; tick();
    id1 = 32'h44; tick();
    iv1 = 1'b0;
    rst_n = 1'b0; tick();
    checkOutput("rst_mid_valid_ready", {30'd0, ov1, ir1}, 32'd0);
    rst_n = 1'b1; tick();
    checkOutput("rst_mid_ready_back", {30'd0, ov1, ir1}, 32'd1);
    or1 = 1'b1; tick(3);
    checkOutput("no_stale", 32'(ov1), 32'd0);

    // Random streaming on both instances
    xfers = 0; cyc = 0;
    while (xfers < 100 && cyc < 3000) begin
      iv1 = ($urandom_range(0, 3) != 0); id1 = $urandom(); im1 = 3'($urandom_range(0, 7));
      or1 = ($urandom_range(0, 2) != 0); clr1 = ($urandom_range(0, 31) == 0);
      iv0 = ($urandom_range(0, 1) != 0); id0 = 3'($urandom_range(0, 7)); im0 = 3'($urandom_range(0, 7));
      or0 = ($urandom_range(0, 2) != 0); clr0 = ($urandom_range(0, 31) == 0);
      if (iv1 && ir1) xfers++;
      tick();
      cyc++;
    end
    checkOutput("random_xfer_count", 32'(xfers), 32'd100);
    iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    tick(4);
  endtask

  initial begin
    cntMax[0] = 65535; cntMax[1] = 3;
    rst_n = 1'b0;
    iv0 = 1'b0; id0 = '0; im0 = '0; or0 = 1'b0; clr0 = 1'b0;
    iv1 = 1'b0; id1 = '0; im1 = '0; or1 = 1'b0; clr1 = 1'b0;
    applyStimulus();
    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
